// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and character constants for the UART command parser.
package uart_cmd_parser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_OP = 2'd1,
    DIGITS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_I = 2'd0,
    OP_D = 2'd1,
    OP_R = 2'd2
  } op_t;

  localparam logic [7:0] CH_V  = 8'h56;
  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam int DIGIT_LIMIT = 3;
  localparam int ACC_W       = 10;

  // Only ASCII a-z fold; bytes with bit 7 set fall through unchanged.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in from uart_rx, commanded value and status out to the display rows.
interface uart_cmd_parser_if;
  logic       byteReady;
  logic [7:0] data;
  logic [7:0] value;
  logic       valueValid;
  logic       errorFlag;
  logic [7:0] cmdCount;

  modport master (
    output byteReady, data,
    input  value, valueValid, errorFlag, cmdCount
  );

  modport slave (
    input  byteReady, data,
    output value, valueValid, errorFlag, cmdCount
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses V<nnn>/I/D/R text commands into an 8-bit value; commit lands one cycle after the terminator edge.
// No backpressure: each byteReady rising edge is consumed immediately; a stalled command aborts on timeout.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input logic              clk,
  input logic              rstN,
  uart_cmd_parser_if.slave bus
);

  localparam int            TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  op_t              r_op, w_op_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [1:0]       r_digits, w_digits_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic             r_br_prev;
  logic [7:0]       r_value;
  logic             r_value_vld;
  logic             r_err;
  logic [7:0]       r_cmd_cnt;

  logic       w_edge;
  logic       w_term;
  logic       w_is_digit;
  logic [7:0] w_ch;
  logic [3:0] w_digit_val;
  logic       w_commit;
  logic       w_reject;
  logic [7:0] w_commit_val;

  assign w_edge      = bus.byteReady & ~r_br_prev;
  assign w_ch        = to_upper(bus.data);
  assign w_term      = is_term(bus.data);
  assign w_is_digit  = (bus.data >= CH_0) && (bus.data <= CH_9);
  assign w_digit_val = 4'(bus.data - CH_0);

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_acc_nxt    = r_acc;
    w_digits_nxt = r_digits;
    w_commit     = 1'b0;
    w_reject     = 1'b0;

    if (w_edge) begin
      case (r_state)
        IDLE: begin
          if (w_ch == CH_V) begin
            w_state_nxt  = DIGITS;
            w_acc_nxt    = '0;
            w_digits_nxt = 2'd0;
          end else if (w_ch == CH_I) begin
            w_state_nxt = GOT_OP;
            w_op_nxt    = OP_I;
          end else if (w_ch == CH_D) begin
            w_state_nxt = GOT_OP;
            w_op_nxt    = OP_D;
          end else if (w_ch == CH_R) begin
            w_state_nxt = GOT_OP;
            w_op_nxt    = OP_R;
          end else if (!(w_term || (bus.data == CH_SP))) begin
            w_state_nxt = ERROR;
          end
        end
        GOT_OP: begin
          if (w_term) begin
            w_commit    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = ERROR;
          end
        end
        DIGITS: begin
          if (w_is_digit) begin
            if (r_digits == 2'(DIGIT_LIMIT)) begin
              w_state_nxt = ERROR;
            end else begin
              // At most 99*10+9 before the third digit lands, so 10 bits never overflow.
              w_acc_nxt    = ACC_W'(r_acc * 10'd10 + {6'd0, w_digit_val});
              w_digits_nxt = r_digits + 2'd1;
            end
          end else if (w_term) begin
            w_commit    = (r_digits != 2'd0);
            w_reject    = (r_digits == 2'd0);
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = ERROR;
          end
        end
        default: begin
          if (w_term) begin
            w_reject    = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      endcase
    end else if ((r_state != IDLE) && (r_timer == TIMER_LAST)) begin
      w_reject    = 1'b1;
      w_state_nxt = IDLE;
    end
  end

  // A consumed byte always restarts the timer, so it wins over a same-cycle expiry.
  assign w_timer_nxt = ((w_state_nxt == IDLE) || w_edge) ? '0 : (r_timer + 1'b1);

  always_comb begin
    w_commit_val = r_value;
    if (r_state == DIGITS) begin
      w_commit_val = (r_acc > 10'd255) ? 8'hFF : r_acc[7:0];
    end else begin
      case (r_op)
        OP_I:    w_commit_val = r_value + 8'd1;
        OP_D:    w_commit_val = r_value - 8'd1;
        default: w_commit_val = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= IDLE;
      r_op        <= OP_I;
      r_acc       <= '0;
      r_digits    <= 2'd0;
      r_timer     <= '0;
      r_br_prev   <= 1'b1;
      r_value     <= 8'd0;
      r_value_vld <= 1'b0;
      r_err       <= 1'b0;
      r_cmd_cnt   <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_acc       <= w_acc_nxt;
      r_digits    <= w_digits_nxt;
      r_timer     <= w_timer_nxt;
      r_br_prev   <= bus.byteReady;
      r_value_vld <= w_commit;
      if (w_commit) begin
        r_value   <= w_commit_val;
        r_err     <= 1'b0;
        r_cmd_cnt <= r_cmd_cnt + 8'd1;
      end else if (w_reject) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.value      = r_value;
  assign bus.valueValid = r_value_vld;
  assign bus.errorFlag  = r_err;
  assign bus.cmdCount   = r_cmd_cnt;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Drives text commands into uart_cmd_parser and compares against a line-buffer model of the command grammar.
module tb_uart_cmd_parser;

  localparam int TO = 100;

  logic clk = 1'b0;
  logic rstN;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int vv_pulses = 0;

  always @(negedge clk) begin
    if (bus.valueValid === 1'b1) vv_pulses <= vv_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Model: bytes of the current command are buffered; the whole line is judged at its terminator.
  int         m_value, m_err, m_cnt;
  logic [7:0] m_buf[$];

  function automatic logic [7:0] up(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  task automatic model_reset();
    m_value = 0; m_err = 0; m_cnt = 0;
    m_buf.delete();
  endtask

  task automatic model_timeout();
    if (m_buf.size() > 0) begin
      m_err = 1;
      m_buf.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output bit commit);
    bit is_t, ok;
    int n, nv;
    logic [7:0] u;
    commit = 0;
    is_t = (b == 8'h0D) || (b == 8'h0A);
    if (m_buf.size() == 0 && (is_t || b == 8'h20)) return;
    if (!is_t) begin
      m_buf.push_back(b);
      return;
    end
    u  = up(m_buf[0]);
    ok = 0;
    nv = m_value;
    if (u == 8'h56 && m_buf.size() >= 2 && m_buf.size() <= 4) begin
      ok = 1; n = 0;
      for (int i = 1; i < m_buf.size(); i++) begin
        if (m_buf[i] < 8'h30 || m_buf[i] > 8'h39) ok = 0;
        else n = n * 10 + int'(m_buf[i] - 8'h30);
      end
      nv = (n > 255) ? 255 : n;
    end else if (m_buf.size() == 1 && u == 8'h49) begin
      ok = 1; nv = (m_value + 1) % 256;
    end else if (m_buf.size() == 1 && u == 8'h44) begin
      ok = 1; nv = (m_value + 255) % 256;
    end else if (m_buf.size() == 1 && u == 8'h52) begin
      ok = 1; nv = 0;
    end
    if (ok) begin
      m_value = nv; m_err = 0; m_cnt = (m_cnt + 1) % 256; commit = 1;
    end else begin
      m_err = 1;
    end
    m_buf.delete();
  endtask

  // Entered and left at posedge+1; hold >= 2 cycles high, gap >= 1 cycle low.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap, input string tag);
    bit c;
    model_byte(b, c);
    bus.data      = b;
    bus.byteReady = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_vv"}, 32'(bus.valueValid), 32'(c));
    @(posedge clk); #1;
    check_eq({tag, "_vv_1cyc"}, 32'(bus.valueValid), 0);
    repeat (hold - 2) @(posedge clk);
    #1;
    bus.byteReady = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    check_eq({tag, "_value"}, 32'(bus.value), m_value);
    check_eq({tag, "_err"}, 32'(bus.errorFlag), m_err);
    check_eq({tag, "_cnt"}, 32'(bus.cmdCount), m_cnt);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 2, 1, tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_value0"}, 32'(bus.value), 0);
    check_eq({tag, "_vv0"}, 32'(bus.valueValid), 0);
    check_eq({tag, "_err0"}, 32'(bus.errorFlag), 0);
    check_eq({tag, "_cnt0"}, 32'(bus.cmdCount), 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    check_zero_outputs(tag);
    rstN = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int k, nd;
    string ops;
    logic [7:0] q[$];

    ops           = "IiDdRr";
    bus.byteReady = 1'b0;
    bus.data      = 8'h00;
    rstN          = 1'b1;
    #2 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rstN = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Basic decimal command and pulse timing
    send_str("V123", "v123");
    p0 = vv_pulses;
    send_byte(8'h0D, 2, 1, "v123_cr");
    check_eq("v123_value", 32'(bus.value), 123);
    check_eq("v123_cnt", 32'(bus.cmdCount), 1);
    check_eq("v123_err", 32'(bus.errorFlag), 0);
    check_eq("v123_pulses", vv_pulses - p0, 1);

    // Saturation, then too many digits
    send_str("v999\n", "v999");
    check_eq("v999_sat", 32'(bus.value), 255);
    send_str("V1234\r", "v1234");
    check_eq("v1234_err", 32'(bus.errorFlag), 1);
    check_eq("v1234_value", 32'(bus.value), 255);

    // R / D / I wrap-around
    do_reset("rst_rdi");
    send_str("R\r", "r");
    check_eq("r_value", 32'(bus.value), 0);
    send_str("D\r", "d");
    check_eq("d_wrap", 32'(bus.value), 255);
    send_str("I\r", "i");
    check_eq("i_wrap", 32'(bus.value), 0);
    check_eq("rdi_cnt", 32'(bus.cmdCount), 3);

    // Rejects keep the error flag until an accepted command
    send_str("X5\r", "x5");
    check_eq("x5_err", 32'(bus.errorFlag), 1);
    send_str("V\r", "vempty");
    check_eq("vempty_err", 32'(bus.errorFlag), 1);
    check_eq("vempty_value", 32'(bus.value), 0);
    send_str("V7\r", "v7");
    check_eq("v7_value", 32'(bus.value), 7);
    check_eq("v7_err", 32'(bus.errorFlag), 0);

    // Timeout mid-command
    do_reset("rst_to");
    send_str("V4", "v4");
    repeat (TO - 10) @(posedge clk);
    #1;
    check_eq("to_early_err", 32'(bus.errorFlag), 0);
    repeat (20) @(posedge clk);
    #1;
    model_timeout();
    check_eq("to_err", 32'(bus.errorFlag), 1);
    check_eq("to_value", 32'(bus.value), 0);
    send_str("V9\r", "after_to");
    check_eq("after_to_value", 32'(bus.value), 9);

    // A long byteReady level is one byte
    send_byte(8'h56, 2, 1, "hold_v");
    send_byte(8'h35, 50, 1, "hold_5");
    send_byte(8'h0D, 2, 1, "hold_cr");
    check_eq("hold_value", 32'(bus.value), 5);
    check_eq("hold_cnt", 32'(bus.cmdCount), 2);

    // Reset mid-command, with byteReady high across release
    send_str("V12", "v12");
    rstN = 1'b0;
    @(posedge clk); #1;
    bus.data      = 8'h58;
    bus.byteReady = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midrst");
    rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.byteReady = 1'b0;
    @(posedge clk); #1;
    model_reset();
    send_byte(8'h0D, 2, 1, "midrst_cr");
    check_eq("midrst_err", 32'(bus.errorFlag), 0);
    check_eq("midrst_cnt", 32'(bus.cmdCount), 0);

    // Randomized command mix
    for (int c = 0; c < 80; c++) begin
      q.delete();
      k = $urandom_range(0, 5);
      case (k)
        0, 1: begin
          q.push_back(($urandom_range(0, 1) != 0) ? 8'h56 : 8'h76);
          nd = $urandom_range(0, 4);
          for (int d = 0; d < nd; d++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        end
        2: q.push_back(ops[$urandom_range(0, 5)]);
        3: begin
          nd = $urandom_range(1, 3);
          for (int d = 0; d < nd; d++) q.push_back(8'($urandom_range(0, 255)));
        end
        4: q.push_back(($urandom_range(0, 1) != 0) ? 8'h20 : 8'h0A);
        default: begin
          q.push_back(ops[$urandom_range(0, 5)]);
          q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        end
      endcase
      q.push_back(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      foreach (q[j]) send_byte(q[j], $urandom_range(2, 4), $urandom_range(1, 3), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
